// File: rtl/com_monitor_if.sv
// Command-monitor bus: filtered command line and timebase in,
// start/active/stuck status and duration report out.
// master: filter side (drives tick, in; observes status)
// slave : monitor side (samples tick, in; drives status)
interface com_monitor_if #(
    parameter int CNT_WIDTH = 8
);
    logic                 tick;
    logic                 in;
    logic                 start;
    logic                 active;
    logic                 stuck;
    logic [CNT_WIDTH-1:0] dur;
    logic                 dur_valid;

    modport master (
        output tick, in,
        input  start, active, stuck, dur, dur_valid
    );

    modport slave (
        input  tick, in,
        output start, active, stuck, dur, dur_valid
    );
endinterface

// File: rtl/com_monitor.sv
// Command-activity monitor: detects activation edges, times the
// hold in ticks, flags stuck commands, reports duration on release.
// Ports: clk, aclr_n (sync active-low), bus (com_monitor_if.slave).
module com_monitor #(
    parameter int   CNT_WIDTH    = 8,
    parameter int   TIMEOUT      = 200,
    parameter logic ACTIVE_LEVEL = 1'b0
) (
    input logic           clk,
    input logic           aclr_n,
    com_monitor_if.slave  bus
);
    localparam logic [CNT_WIDTH-1:0] TO = CNT_WIDTH'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        STUCK  = 2'd2
    } state_t;

    state_t               state, state_n;
    logic [CNT_WIDTH-1:0] cnt, cnt_n, cnt_inc;
    logic                 in_d;
    logic                 rise_act, rel;

    logic                 start_r, start_n;
    logic                 active_r, active_n;
    logic                 stuck_r, stuck_n;
    logic [CNT_WIDTH-1:0] dur_r, dur_n;
    logic                 dv_r, dv_n;

    // Edge detection is independent of the timebase.
    assign rise_act = (bus.in == ACTIVE_LEVEL) &&
                      (in_d != ACTIVE_LEVEL);
    assign rel      = (bus.in != ACTIVE_LEVEL);
    // cnt stays below TIMEOUT in ACTIVE, so this cannot wrap.
    assign cnt_inc  = cnt + 1'b1;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        start_n = 1'b0;
        dv_n    = 1'b0;
        dur_n   = dur_r;
        case (state)
            IDLE: begin
                if (rise_act) begin
                    start_n = 1'b1;
                    cnt_n   = '0;
                    state_n = ACTIVE;
                end
            end
            ACTIVE: begin
                // Release wins: a tick on the release clock is dropped.
                if (rel) begin
                    dur_n   = cnt;
                    dv_n    = 1'b1;
                    cnt_n   = '0;
                    state_n = IDLE;
                end else if (bus.tick) begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == TO) begin
                        state_n = STUCK;
                    end
                end
            end
            STUCK: begin
                if (rel) begin
                    dur_n   = TO;
                    dv_n    = 1'b1;
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
        active_n = (state_n != IDLE);
        stuck_n  = (state_n == STUCK);
    end

    always_ff @(posedge clk) begin
        if (!aclr_n) begin
            state    <= IDLE;
            cnt      <= '0;
            in_d     <= ~ACTIVE_LEVEL;
            start_r  <= 1'b0;
            active_r <= 1'b0;
            stuck_r  <= 1'b0;
            dur_r    <= '0;
            dv_r     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            in_d     <= bus.in;
            start_r  <= start_n;
            active_r <= active_n;
            stuck_r  <= stuck_n;
            dur_r    <= dur_n;
            dv_r     <= dv_n;
        end
    end

    assign bus.start     = start_r;
    assign bus.active    = active_r;
    assign bus.stuck     = stuck_r;
    assign bus.dur       = dur_r;
    assign bus.dur_valid = dv_r;
endmodule

// File: tb/tb_com_monitor.sv
// Testbench for com_monitor: directed plan scenarios plus random
// stimulus, checked every cycle against a behavioural model.
module tb_com_monitor;
    localparam int CW = 3;
    localparam int TO = 4;

    logic clk;
    logic aclr_n;
    int   total;
    int   bad;

    com_monitor_if #(.CNT_WIDTH(CW)) bus ();

    com_monitor #(
        .CNT_WIDTH   (CW),
        .TIMEOUT     (TO),
        .ACTIVE_LEVEL(1'b0)
    ) dut (
        .clk   (clk),
        .aclr_n(aclr_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a hold is a run of active samples that began with an
    // inactive->active transition; duration = ticks seen strictly
    // between the starting and releasing samples, capped at TO.
    bit          m_hold;
    int          m_ticks;
    logic        m_prev;
    logic        e_start, e_act, e_stk, e_dv;
    logic [CW-1:0] e_dur;

    always @(posedge clk) begin
        bit          h;
        int          t;
        logic        s, dv;
        logic [CW-1:0] d;
        if (!aclr_n) begin
            m_hold  <= 1'b0;
            m_ticks <= 0;
            m_prev  <= 1'b1;
            e_start <= 1'b0;
            e_act   <= 1'b0;
            e_stk   <= 1'b0;
            e_dur   <= '0;
            e_dv    <= 1'b0;
        end else begin
            h  = m_hold;
            t  = m_ticks;
            s  = 1'b0;
            dv = 1'b0;
            d  = e_dur;
            if (!h) begin
                if (bus.in == 1'b0 && m_prev != 1'b0) begin
                    h = 1'b1;
                    t = 0;
                    s = 1'b1;
                end
            end else if (bus.in != 1'b0) begin
                d  = CW'((t > TO) ? TO : t);
                dv = 1'b1;
                h  = 1'b0;
            end else if (bus.tick) begin
                t = t + 1;
            end
            m_hold  <= h;
            m_ticks <= t;
            m_prev  <= bus.in;
            e_start <= s;
            e_dv    <= dv;
            e_dur   <= d;
            e_act   <= h;
            e_stk   <= h && (t >= TO);
        end
    end

    task automatic cmp(input string n, input int a, input int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s: got %0d want %0d t=%0t",
                     n, a, e, $time);
        end
    endtask

    always @(negedge clk) begin
        cmp("start",     int'(bus.start),     int'(e_start));
        cmp("active",    int'(bus.active),    int'(e_act));
        cmp("stuck",     int'(bus.stuck),     int'(e_stk));
        cmp("dur",       int'(bus.dur),       int'(e_dur));
        cmp("dur_valid", int'(bus.dur_valid), int'(e_dv));
        if (bus.start && bus.dur_valid) begin
            cmp("start_dv_excl", 1, 0);
        end
    end

    task automatic cyc(input logic r, input logic i, input logic t);
        aclr_n   = r;
        bus.in   = i;
        bus.tick = t;
        @(negedge clk);
    endtask

    initial begin
        logic cur;
        total    = 0;
        bad      = 0;
        aclr_n   = 1'b0;
        bus.in   = 1'b1;
        bus.tick = 1'b0;

        // 1: reset
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(1, 1, 0);
            cmp("t1_active", int'(bus.active), 0);
            cmp("t1_dur", int'(bus.dur), 0);
        end

        // 2: normal hold, 3 ticks
        cyc(1, 0, 0);
        cmp("t2_start", int'(bus.start), 1);
        cmp("t2_active", int'(bus.active), 1);
        cyc(1, 0, 1);
        cmp("t2_start_drop", int'(bus.start), 0);
        cyc(1, 0, 1);
        cyc(1, 0, 1);
        cyc(1, 1, 0);
        cmp("t2_dur", int'(bus.dur), 3);
        cmp("t2_dv", int'(bus.dur_valid), 1);
        cmp("t2_active_rel", int'(bus.active), 0);
        cyc(1, 1, 0);
        cmp("t2_dv_drop", int'(bus.dur_valid), 0);

        // 3: stuck
        cyc(1, 0, 1);
        for (int k = 0; k < 3; k++) cyc(1, 0, 1);
        cmp("t3_not_stuck", int'(bus.stuck), 0);
        cyc(1, 0, 1);
        cmp("t3_stuck", int'(bus.stuck), 1);
        for (int k = 0; k < 5; k++) cyc(1, 0, 1);
        cmp("t3_dur_held", int'(bus.dur), 3);
        cyc(1, 1, 0);
        cmp("t3_dur", int'(bus.dur), 4);
        cmp("t3_dv", int'(bus.dur_valid), 1);
        cmp("t3_stuck_rel", int'(bus.stuck), 0);

        // 4: tick on release clock not counted
        cyc(1, 0, 0);
        cyc(1, 0, 1);
        cyc(1, 0, 1);
        cyc(1, 1, 1);
        cmp("t4_dur", int'(bus.dur), 2);

        // 5: reset mid-hold
        cyc(1, 0, 0);
        cyc(1, 0, 1);
        cyc(1, 0, 1);
        cyc(0, 0, 1);
        cmp("t5_active", int'(bus.active), 0);
        cmp("t5_dv", int'(bus.dur_valid), 0);
        cmp("t5_dur", int'(bus.dur), 0);
        cyc(1, 0, 0);
        cmp("t5_start", int'(bus.start), 1);
        cyc(1, 0, 1);
        cyc(1, 1, 0);
        cmp("t5_dur_new", int'(bus.dur), 1);

        // 6: no ticks, then immediate re-activation
        for (int k = 0; k < 10; k++) cyc(1, 0, 0);
        cyc(1, 1, 0);
        cmp("t6_dur0", int'(bus.dur), 0);
        cmp("t6_dv", int'(bus.dur_valid), 1);
        cyc(1, 0, 0);
        cmp("t6_start2", int'(bus.start), 1);
        cyc(1, 0, 1);
        cyc(1, 0, 1);
        cyc(1, 1, 0);
        cmp("t6_dur2", int'(bus.dur), 2);

        // random
        cur = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(5) == 0) cur = ~cur;
            cyc(($urandom_range(99) != 0), cur,
                logic'($urandom_range(1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/com_monitor.md
# com_monitor

Command-activity monitor placed directly downstream of the single-bit input filter. Consumes the filter's debounced command line, detects activation edges, reports a one-clock start pulse and a hold level, measures activation duration in timebase ticks, and flags commands held active past a timeout. Duration is reported on release with a one-clock valid strobe.

## Interface

Parameters:
- CNT_WIDTH, 8, width of the duration counter and `dur` output.
- TIMEOUT, 200, tick count after which an active command is declared stuck. Legal range is 1 ≤ TIMEOUT ≤ 2^CNT_WIDTH−1.
- ACTIVE_LEVEL, 1'b0, level of `in` meaning "command active". The filter's default output 1'b1 is inactive.

Ports:
- clk, in, 1, system clock. All logic is on the rising edge.
- aclr_n, in, 1, reset. Synchronous, active-low, sampled on the `clk` rising edge.
- tick, in, 1, timebase enable. The counter advances only on clocks where tick=1.
- in, in, 1, filtered command line (filter output).
- start, out, 1, one-clock pulse on activation.
- active, out, 1, high while the command is active (ACTIVE or STUCK).
- stuck, out, 1, high while the command has been active for ≥ TIMEOUT ticks.
- dur, out, CNT_WIDTH, duration of the last completed activation in ticks. Held until the next release.
- dur_valid, out, 1, one-clock strobe when `dur` updates.

## Operation

- Internal registers:
  - `in_d`: previous sample of `in`. Reset value is ~ACTIVE_LEVEL.
  - `cnt`: CNT_WIDTH bits.
  - `state`: one of IDLE, ACTIVE, STUCK.
- Edge detection runs every clk and is not gated by tick:
  - rise_act = (in==ACTIVE_LEVEL) && (in_d!=ACTIVE_LEVEL)
  - release = (in!=ACTIVE_LEVEL)
- Reset (aclr_n=0 at an edge):
  - state=IDLE, cnt=0, in_d=~ACTIVE_LEVEL.
  - start=0, active=0, stuck=0, dur=0, dur_valid=0.
  - An aborted activation produces no dur_valid.
  - Reset overrides every other event.
- IDLE:
  - On rise_act: start=1 for one clock, active=1, cnt=0, go to ACTIVE.
  - Otherwise remain in IDLE with outputs low. Release while in IDLE has no effect.
- ACTIVE:
  - release has priority over tick: dur=cnt, dur_valid=1 for one clock, active=0, cnt=0, go to IDLE. A tick on the release clock is not counted.
  - Otherwise, if tick=1: cnt=cnt+1. If cnt+1==TIMEOUT, set stuck=1 and go to STUCK.
- STUCK:
  - cnt frozen at TIMEOUT. tick is ignored.
  - On release: dur=TIMEOUT, dur_valid=1, stuck=0, active=0, cnt=0, go to IDLE.
- `cnt` never exceeds TIMEOUT, so no wrap-around is possible.
- `in` held active through reset: `in_d` resets to inactive, so rise_act fires on the first clock after aclr_n returns high. start follows one clock later. This is intentional: a command present at power-up is reported.
- Re-activation on the clock directly after release is a new rise_act and is handled from IDLE normally.
- No unknown states: any illegal state encoding returns to IDLE.

## Timing

- All outputs are registered.
- If the edge sampling rise_act is edge N, start and active are high after edge N; start drops after edge N+1.
- If the edge sampling release is edge M, dur_valid and updated dur are visible after M; dur_valid drops after M+1. active and stuck drop after M.
- stuck rises after the edge on which the TIMEOUT-th tick is sampled.
- Latency from `in` change to response is 1 clk. There is no combinational path from inputs to outputs.
- dur_valid and start are never high on the same clock.

## Test plan

Common settings: CNT_WIDTH=3, TIMEOUT=4, ACTIVE_LEVEL=0.

1. Reset: in=1, aclr_n=0 for 2 clk, then aclr_n=1 for 3 clk -> start=active=stuck=dur_valid=0, dur=0 throughout.
2. Normal command: in 1→0; 3 clocks with tick=1; then in=1 -> start pulse exactly 1 clk after the edge; active=1 for the whole hold; on release dur=3 with a single dur_valid pulse; stuck stays 0.
3. Stuck: in=0 with ticks on every clock -> stuck=1 after the 4th tick. Keep in=0 for 5 more ticks -> dur remains unchanged. Then in=1 -> dur=4, dur_valid pulse, stuck=0, active=0.
4. Simultaneous tick and release at cnt=2 -> dur=2, not 3.
5. Reset mid-ACTIVE (cnt=2, aclr_n=0 for 1 clk, in held 0) -> all outputs 0 with no dur_valid. After reset release, start pulses again and the new activation counts from 0.
6. tick=0 for a 10-clk activation -> dur=0 and dur_valid pulses. Follow immediately with re-activation one clock after release -> second start pulse, correct independent dur.
